// File: rtl/alu_issue.sv
// Decode/issue stage for RV32I OP, OP-IMM, LUI and AUIPC. Operands are decoded and
// handed to the ALU through a registered two-entry (main + skid) buffer.
//   state | meaning
//   EMPTY | no entry held, o_valid low
//   ONE   | main entry presented to the ALU
//   FULL  | main presented, skid holds the next entry, o_ready low
module alu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_instr,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [4:0]            o_rd,
    output logic                  o_illegal
);
    localparam logic [OP_WIDTH-1:0] OP_ALU_NOP = 6'd0;
    localparam logic [OP_WIDTH-1:0] OP_ALU_ADD = 6'd1;
    localparam logic [OP_WIDTH-1:0] OP_ALU_SUB = 6'd2;
    localparam logic [OP_WIDTH-1:0] OP_ALU_AND = 6'd3;
    localparam logic [OP_WIDTH-1:0] OP_ALU_OR  = 6'd4;
    localparam logic [OP_WIDTH-1:0] OP_ALU_XOR = 6'd5;
    localparam logic [OP_WIDTH-1:0] OP_ALU_SLT = 6'd6;
    localparam logic [OP_WIDTH-1:0] OP_ALU_SLL = 6'd7;
    localparam logic [OP_WIDTH-1:0] OP_ALU_SRL = 6'd8;
    localparam logic [OP_WIDTH-1:0] OP_ALU_SRA = 6'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic                  illegal;
        logic [OP_WIDTH-1:0]   op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [4:0]            rd;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{illegal: 1'b0, op: OP_ALU_NOP, a: '0, b: '0, rd: '0};

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, dec;
    logic   ready_q, ready_d;
    logic   accept, drain;

    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic                  legal;
    logic [OP_WIDTH-1:0]   dec_op;
    logic [DATA_WIDTH-1:0] dec_a, dec_b, imm_i, imm_u, shamt_i, shamt_r;
    logic                  unused_rs1_idx;

    assign opcode  = i_instr[6:0];
    assign f3      = i_instr[14:12];
    assign f7      = i_instr[31:25];
    assign imm_i   = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:20]};
    assign imm_u   = {i_instr[31:12], {(DATA_WIDTH-20){1'b0}}};
    assign shamt_i = {{(DATA_WIDTH-5){1'b0}}, i_instr[24:20]};
    assign shamt_r = {{(DATA_WIDTH-5){1'b0}}, i_rs2_data[4:0]};
    // Register indices were already consumed by the register-file read.
    assign unused_rs1_idx = ^i_instr[19:15];

    always_comb begin
        legal  = 1'b0;
        dec_op = OP_ALU_NOP;
        dec_a  = i_rs1_data;
        dec_b  = i_rs2_data;
        unique case (opcode)
            OPC_OP: begin
                unique case (f3)
                    3'b000: begin
                        legal  = (f7 == 7'h00) || (f7 == 7'h20);
                        dec_op = f7[5] ? OP_ALU_SUB : OP_ALU_ADD;
                    end
                    3'b111: begin legal = (f7 == 7'h00); dec_op = OP_ALU_AND; end
                    3'b110: begin legal = (f7 == 7'h00); dec_op = OP_ALU_OR;  end
                    3'b100: begin legal = (f7 == 7'h00); dec_op = OP_ALU_XOR; end
                    3'b010: begin legal = (f7 == 7'h00); dec_op = OP_ALU_SLT; end
                    3'b001: begin
                        legal  = (f7 == 7'h00);
                        dec_op = OP_ALU_SLL;
                        dec_b  = shamt_r;
                    end
                    3'b101: begin
                        legal  = (f7 == 7'h00) || (f7 == 7'h20);
                        dec_op = f7[5] ? OP_ALU_SRA : OP_ALU_SRL;
                        dec_b  = shamt_r;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                dec_b = imm_i;
                unique case (f3)
                    3'b000: begin legal = 1'b1; dec_op = OP_ALU_ADD; end
                    3'b111: begin legal = 1'b1; dec_op = OP_ALU_AND; end
                    3'b110: begin legal = 1'b1; dec_op = OP_ALU_OR;  end
                    3'b100: begin legal = 1'b1; dec_op = OP_ALU_XOR; end
                    3'b010: begin legal = 1'b1; dec_op = OP_ALU_SLT; end
                    3'b001: begin
                        legal  = (f7 == 7'h00);
                        dec_op = OP_ALU_SLL;
                        dec_b  = shamt_i;
                    end
                    3'b101: begin
                        legal  = (f7 == 7'h00) || (f7 == 7'h20);
                        dec_op = i_instr[30] ? OP_ALU_SRA : OP_ALU_SRL;
                        dec_b  = shamt_i;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal  = 1'b1;
                dec_op = OP_ALU_ADD;
                dec_a  = '0;
                dec_b  = imm_u;
            end
            OPC_AUIPC: begin
                legal  = 1'b1;
                dec_op = OP_ALU_ADD;
                dec_a  = i_pc;
                dec_b  = imm_u;
            end
            default: legal = 1'b0;
        endcase

        // Illegal forms still issue, scrubbed, so the exception is raised downstream.
        if (legal) begin
            dec = '{illegal: 1'b0, op: dec_op, a: dec_a, b: dec_b, rd: i_instr[11:7]};
        end else begin
            dec = '{illegal: 1'b1, op: OP_ALU_NOP, a: '0, b: '0, rd: '0};
        end
    end

    assign accept = i_valid && ready_q;
    assign drain  = (state_q != EMPTY) && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            main_q  <= ENTRY_RESET;
            skid_q  <= ENTRY_RESET;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = dec;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_d = FULL;
                    skid_d  = dec;
                end else if (accept && drain) begin
                    main_d = dec;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (i_flush) begin
            state_d = EMPTY;
        end
        ready_d = (state_d != FULL);
    end

    always_comb begin
        o_valid   = (state_q != EMPTY);
        o_ready   = ready_q;
        o_alu_op  = main_q.op;
        o_a       = main_q.a;
        o_b       = main_q.b;
        o_rd      = main_q.rd;
        o_illegal = main_q.illegal;
    end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure, flush and reset.
module tb_alu_issue;
    localparam logic [5:0] NOP = 6'd0;
    localparam logic [5:0] ADD = 6'd1;
    localparam logic [5:0] SUB = 6'd2;
    localparam logic [5:0] SLL = 6'd7;
    localparam logic [5:0] SRA = 6'd9;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [5:0]  o_alu_op;
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic [4:0]  o_rd;
    logic        o_illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_alu_op(o_alu_op), .o_a(o_a), .o_b(o_b),
        .o_rd(o_rd), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " valid"},   32'(o_valid),   32'd0);
        check({tag, " ready"},   32'(o_ready),   32'd1);
        check({tag, " op"},      32'(o_alu_op),  32'(NOP));
        check({tag, " a"},       o_a,            32'd0);
        check({tag, " b"},       o_b,            32'd0);
        check({tag, " rd"},      32'(o_rd),      32'd0);
        check({tag, " illegal"}, 32'(o_illegal), 32'd0);
    endtask

    task automatic check_issue(input string tag, input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic ill);
        check({tag, " valid"},   32'(o_valid),   32'd1);
        check({tag, " op"},      32'(o_alu_op),  32'(op));
        check({tag, " a"},       o_a,            a);
        check({tag, " b"},       o_b,            b);
        check({tag, " rd"},      32'(o_rd),      32'(rd));
        check({tag, " illegal"}, 32'(o_illegal), 32'(ill));
    endtask

    // Issue one instruction with i_ready high, check the next-cycle outputs, let it drain.
    task automatic issue_one(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] pc,
                             input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic ill);
        i_ready    = 1'b1;
        i_valid    = 1'b1;
        i_instr    = instr;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
        i_pc       = pc;
        step();
        i_valid = 1'b0;
        check_issue(tag, op, a, b, rd, ill);
        step();
        check({tag, " drained"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        repeat (3) step();
        check_reset_outputs("reset");
        i_rst_n = 1'b1;
        step();

        issue_one("addi", 32'hFFF08293, 32'd5, 32'd0, 32'd0, ADD, 32'd5, 32'hFFFFFFFF, 5'd5, 1'b0);
        issue_one("srai", 32'h40315193, 32'hFFFFFFF0, 32'd0, 32'd0, SRA, 32'hFFFFFFF0, 32'd3, 5'd3, 1'b0);
        issue_one("lui", 32'h123450B7, 32'hDEADBEEF, 32'd0, 32'd0, ADD, 32'd0, 32'h12345000, 5'd1, 1'b0);
        issue_one("auipc", 32'h12345097, 32'hDEADBEEF, 32'd0, 32'h100, ADD, 32'h100, 32'h12345000, 5'd1, 1'b0);
        issue_one("sub", 32'h402081B3, 32'd10, 32'd3, 32'd0, SUB, 32'd10, 32'd3, 5'd3, 1'b0);
        issue_one("sll", 32'h002091B3, 32'd7, 32'hFFFFFF25, 32'd0, SLL, 32'd7, 32'd5, 5'd3, 1'b0);
        issue_one("opc7f", 32'h00000FFF, 32'h11, 32'h22, 32'd0, NOP, 32'd0, 32'd0, 5'd0, 1'b1);
        issue_one("sltu", 32'h0020B1B3, 32'h11, 32'h22, 32'd0, NOP, 32'd0, 32'd0, 5'd0, 1'b1);
        issue_one("badf7", 32'h022081B3, 32'h11, 32'h22, 32'd0, NOP, 32'd0, 32'd0, 5'd0, 1'b1);

        // Back-to-back at full rate
        i_ready = 1'b1;
        i_rs1_data = 32'd0;
        i_valid = 1'b1; i_instr = 32'h00100093; step();
        check("thru1 rd", 32'(o_rd), 32'd1);
        i_instr = 32'h00200113; step();
        check("thru2 rd", 32'(o_rd), 32'd2);
        check("thru2 ready", 32'(o_ready), 32'd1);
        i_instr = 32'h00300193; step();
        check("thru3 rd", 32'(o_rd), 32'd3);
        check("thru3 ready", 32'(o_ready), 32'd1);
        i_valid = 1'b0; step();
        check("thru end valid", 32'(o_valid), 32'd0);

        // Backpressure: A and B accepted, C stalls until the buffer drains
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = 32'h00100093; step();
        check_issue("bp A", ADD, 32'd0, 32'd1, 5'd1, 1'b0);
        check("bp A ready", 32'(o_ready), 32'd1);
        i_instr = 32'h00200113; step();
        check("bp full ready", 32'(o_ready), 32'd0);
        check_issue("bp hold0", ADD, 32'd0, 32'd1, 5'd1, 1'b0);
        i_instr = 32'h00300193;
        step();
        check("bp stall1 ready", 32'(o_ready), 32'd0);
        check_issue("bp hold1", ADD, 32'd0, 32'd1, 5'd1, 1'b0);
        step();
        check_issue("bp hold2", ADD, 32'd0, 32'd1, 5'd1, 1'b0);
        i_ready = 1'b1;
        step();
        check_issue("bp B", ADD, 32'd0, 32'd2, 5'd2, 1'b0);
        check("bp B ready", 32'(o_ready), 32'd1);
        step();
        i_valid = 1'b0;
        check_issue("bp C", ADD, 32'd0, 32'd3, 5'd3, 1'b0);
        step();
        check("bp end valid", 32'(o_valid), 32'd0);

        // Flush with a full buffer; the same-cycle input is dropped
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = 32'h00100093; step();
        i_instr = 32'h00200113; step();
        check("fl full ready", 32'(o_ready), 32'd0);
        i_flush = 1'b1; i_instr = 32'h00300193; step();
        i_flush = 1'b0; i_valid = 1'b0;
        check("fl valid", 32'(o_valid), 32'd0);
        check("fl ready", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        step();
        check("fl dropped", 32'(o_valid), 32'd0);

        // Asynchronous reset mid-stream
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = 32'h00100093; step();
        i_instr = 32'h00200113; step();
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        step();
        i_rst_n = 1'b1;
        step();
        check("rst release ready", 32'(o_ready), 32'd1);
        check("rst release valid", 32'(o_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
